m_fetch_queue: RTL and testbench
================================

// Module: m_fetch_queue
// PURPOSE
//  Instruction-fetch front end for the 5-stage pipeline; sits between instruction memory and ID.
//  - Drives a synchronous-read imem: 1-cycle latency, 12-bit word address.
//  - Buffers fetched words in a DEPTH-entry FIFO so ID can stall without losing or refetching instructions.
//  - Accepts branch redirects from ID and supports a single architectural delay slot.
// PARAMETERS
//  DEPTH      4     FIFO entries; power of 2, >=2
//  ADDR_W     12    imem word-address width
//  RESET_PC   0     byte PC fetched first after reset
//  DELAY_SLOT 1     1: keep the one instruction after a taken branch; 0: flush everything
// PORTS
//  w_clk       in   1       clock; all state updates on posedge
//  w_rst       in   1       synchronous reset, active high
//  w_stall     in   1       ID cannot accept the head this cycle
//  w_redirect  in   1       taken branch in ID (ID is consuming the head this cycle)
//  w_tpc       in   32      branch target byte address, valid with w_redirect
//  w_halt      in   1       stop issuing new fetches
//  w_imem_addr out  ADDR_W  = r_fpc[ADDR_W+1:2], combinational
//  w_imem_en   out  1       fetch issued this cycle
//  w_imem_data in   32      imem read data; valid the cycle after w_imem_en
//  w_valid     out  1       FIFO head holds an instruction
//  w_ir        out  32      head instruction; 32'h00000020 (NOP) when !w_valid
//  w_pc        out  32      head byte PC; 0 when !w_valid
//  w_pc4       out  32      w_pc + 4
//  w_count     out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Registers
//  - r_fpc: next fetch PC.
//  - r_inf / r_inf_pc: one in-flight request.
//  - FIFO: entries of {pc, ir}.
//  Reset (w_rst=1 at an edge)
//  - r_fpc=RESET_PC, r_inf=0, FIFO empty.
//  - Outputs then: w_valid=0, w_ir=NOP, w_count=0.
//  - Applies mid-operation too: in-flight data is discarded.
//  Priority: w_rst > w_redirect > w_halt.
//  Pop and push
//  - pop  = w_valid & ~w_stall.
//  - push = r_inf; captures {r_inf_pc, w_imem_data}.
//  - Push and pop may occur in the same cycle; occupancy is then unchanged.
//  Issue
//  - w_imem_en = ~w_rst & ~w_redirect & ~w_halt & (w_count + r_inf < DEPTH).
//  - On issue: r_inf<=1, r_inf_pc<=r_fpc, r_fpc<=r_fpc+4 (32-bit, wraps modulo 2^32).
//  - Without issue: r_inf<=0.
//  - The credit rule guarantees push never hits a full FIFO; overflow is impossible by construction.
//  Latency and throughput
//  - First w_valid at the 2nd edge after the reset edge.
//  - Sustains 1 instruction/cycle with w_stall=0.
//  Redirect (sampled only when pop=1)
//  - The branch (head) is popped.
//  - DELAY_SLOT=1: keep the next-oldest FIFO entry if present, otherwise keep the in-flight request; discard everything else.
//  - If neither exists, the slot is lost, i.e. executes as NOP.
//  - DELAY_SLOT=0: discard all entries and the in-flight request.
//  - r_fpc<=w_tpc; no issue in the redirect cycle.
//  - The target reaches w_valid 2 edges after the redirect edge.
//  - w_redirect with w_stall=1 is ignored.
//  Halt
//  - Issue stops; r_fpc holds; the in-flight word is still pushed.
//  - The FIFO drains normally; clearing w_halt resumes fetch at r_fpc.
//  - w_tpc[1:0] is ignored (word aligned).
// TESTING
//  1. imem[i]=i, w_stall=0 after reset -> w_valid at 2nd edge; w_pc 0,4,8,... one per cycle; w_ir 0,1,2; w_pc4=w_pc+4.
//  2. Hold w_stall 6 cycles while w_pc=8 -> w_count reaches 4, w_imem_en=0, head stays 8; on release w_pc 8,12,16,20,24 with no gaps or duplicates.
//  3. DELAY_SLOT=1, redirect when w_pc=0x10, w_tpc=0x40 -> consumed sequence 0x10,0x14,0x40,0x44; none of 0x18..0x3c appears.
//  4. DELAY_SLOT=0, same stimulus -> consumed sequence 0x10,0x40,0x44.
//  5. w_halt=1 with 3 entries, no stall -> w_imem_en=0 next cycle; 4 instructions drain (3 plus in-flight); then w_valid=0, w_ir=0x20.
//  6. w_rst=1 with w_count=3 and r_inf=1 -> next cycle w_count=0, w_valid=0; fetch restarts at RESET_PC; stale in-flight data never appears.

Source files
------------

// File: rtl/m_fetch_queue.sv
// Instruction-fetch front end: drives a synchronous-read imem and buffers
// fetched words in a small FIFO in front of ID, with branch redirect and
// single delay-slot handling.
//
// Ports
//   w_clk, w_rst       clock, synchronous active-high reset
//   w_stall            ID cannot take the head this cycle
//   w_redirect, w_tpc  taken branch in ID and its byte target
//   w_halt             stop issuing new fetches
//   w_imem_addr/en     imem word address and fetch strobe
//   w_imem_data        imem read data, valid the cycle after w_imem_en
//   w_valid, w_ir, w_pc, w_pc4  FIFO head towards ID
//   w_count            FIFO occupancy
module m_fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic                       w_stall,
    input  logic                       w_redirect,
    input  logic [31:0]                w_tpc,
    input  logic                       w_halt,
    output logic [ADDR_W-1:0]          w_imem_addr,
    output logic                       w_imem_en,
    input  logic [31:0]                w_imem_data,
    output logic                       w_valid,
    output logic [31:0]                w_ir,
    output logic [31:0]                w_pc,
    output logic [31:0]                w_pc4,
    output logic [$clog2(DEPTH):0]     w_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic [31:0]   r_fpc;
    logic          r_inf;
    logic [31:0]   r_inf_pc;

    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   ir_q [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic          pop;
    logic          take;
    logic          keep_inf;
    logic          push;
    logic [CW:0]   occ;
    logic [PW-1:0] rd_nxt;
    logic [PW-1:0] wr_nxt;
    logic [31:0]   tgt;

    assign w_valid     = (r_cnt != '0);
    assign w_ir        = w_valid ? ir_q[r_rd] : NOP;
    assign w_pc        = w_valid ? pc_q[r_rd] : 32'h0;
    assign w_pc4       = w_pc + 32'd4;
    assign w_count     = r_cnt;
    assign w_imem_addr = r_fpc[ADDR_W+1:2];

    assign pop    = w_valid & ~w_stall;
    assign take   = pop & w_redirect;
    assign rd_nxt = r_rd + PW'(1);
    assign wr_nxt = r_wr + PW'(1);
    assign tgt    = w_tpc & ~32'h3;

    // The in-flight word survives a redirect only as the delay slot, i.e.
    // when the branch is the sole FIFO entry.
    assign keep_inf = take & DELAY_SLOT & (r_cnt == CW'(1));
    assign push     = r_inf & ~w_rst & (~take | keep_inf);

    // Counting the in-flight request as occupied guarantees room for it.
    assign occ = {1'b0, r_cnt} + {{CW{1'b0}}, r_inf};
    assign w_imem_en = ~w_rst & ~w_redirect & ~w_halt
                     & (occ < (CW+1)'(DEPTH));

    always_ff @(posedge w_clk) begin
        if (push) begin
            pc_q[r_wr] <= r_inf_pc;
            ir_q[r_wr] <= w_imem_data;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_fpc    <= RESET_PC;
            r_inf    <= 1'b0;
            r_inf_pc <= 32'h0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_cnt    <= '0;
        end else if (take) begin
            r_fpc <= tgt;
            r_inf <= 1'b0;
            if (DELAY_SLOT && r_cnt >= CW'(2)) begin
                // Next-oldest entry becomes the only one left.
                r_rd  <= rd_nxt;
                r_wr  <= rd_nxt + PW'(1);
                r_cnt <= CW'(1);
            end else if (keep_inf && r_inf) begin
                r_rd  <= rd_nxt;
                r_wr  <= wr_nxt;
                r_cnt <= CW'(1);
            end else begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end
        end else begin
            if (pop)
                r_rd <= rd_nxt;
            if (push)
                r_wr <= wr_nxt;
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
            if (w_imem_en) begin
                r_inf    <= 1'b1;
                r_inf_pc <= r_fpc;
                r_fpc    <= r_fpc + 32'd4;
            end else begin
                r_inf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue: one instance with the delay slot and
// one without, sharing stimulus, each fed by its own imem where imem[i]=i.
module tb_m_fetch_queue;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] tpc;
    logic        halt;

    logic [11:0] addr1, addr0;
    logic        en1, en0;
    logic [31:0] data1, data0;
    logic        v1, v0;
    logic [31:0] ir1, ir0, pc1, pc0, pc41, pc40;
    logic [2:0]  cnt1, cnt0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] q1[$];
    logic [31:0] q0[$];

    m_fetch_queue #(.DELAY_SLOT(1'b1)) u_ds1 (
        .w_clk(clk), .w_rst(rst), .w_stall(stall),
        .w_redirect(redirect), .w_tpc(tpc), .w_halt(halt),
        .w_imem_addr(addr1), .w_imem_en(en1), .w_imem_data(data1),
        .w_valid(v1), .w_ir(ir1), .w_pc(pc1), .w_pc4(pc41),
        .w_count(cnt1)
    );

    m_fetch_queue #(.DELAY_SLOT(1'b0)) u_ds0 (
        .w_clk(clk), .w_rst(rst), .w_stall(stall),
        .w_redirect(redirect), .w_tpc(tpc), .w_halt(halt),
        .w_imem_addr(addr0), .w_imem_en(en0), .w_imem_data(data0),
        .w_valid(v0), .w_ir(ir0), .w_pc(pc0), .w_pc4(pc40),
        .w_count(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en1) data1 <= 32'(addr1);
        if (en0) data0 <= 32'(addr0);
    end

    always @(posedge clk) begin
        if (v1 && !stall) q1.push_back(pc1);
        if (v0 && !stall) q0.push_back(pc0);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hdead_beef;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        step;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        tpc = 32'h0; halt = 1'b0;
        step;
        step;
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_ir", ir1, 32'h20);
        check("rst_count", 32'(cnt1), 32'd0);
        check("rst_pc", pc1, 32'd0);
        check("rst_en", 32'(en1), 32'd0);

        // Streaming after reset
        rst = 1'b0;
        step;
        check("lat_e1_valid", 32'(v1), 32'd0);
        check("lat_e1_en", 32'(en1), 32'd1);
        step;
        check("lat_e2_valid", 32'(v1), 32'd1);
        check("lat_e2_pc", pc1, 32'h0);
        check("lat_e2_ir", ir1, 32'h0);
        check("lat_e2_pc4", pc41, 32'h4);
        step;
        check("s1_pc", pc1, 32'h4);
        check("s1_ir", ir1, 32'h1);
        step;
        check("s2_pc", pc1, 32'h8);
        check("s2_ir", ir1, 32'h2);
        check("s2_pc4", pc41, 32'hc);

        // Stall fills the FIFO
        stall = 1'b1;
        repeat (6) step;
        check("stall_count", 32'(cnt1), 32'd4);
        check("stall_en", 32'(en1), 32'd0);
        check("stall_pc", pc1, 32'h8);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("drain_pc", pc1, 32'h8 + 32'(4 * i));
            check("drain_ir", ir1, 32'h2 + 32'(i));
            step;
        end

        // Redirect, both delay-slot variants
        do_reset;
        for (int i = 0; i < 20 && pc1 != 32'h10; i++) step;
        check("redir_reach", pc1, 32'h10);
        q1.delete();
        q0.delete();
        redirect = 1'b1;
        tpc = 32'h43;
        step;
        redirect = 1'b0;
        step;
        check("ds0_r1_valid", 32'(v0), 32'd0);
        step;
        check("ds0_r2_valid", 32'(v0), 32'd1);
        check("ds0_r2_pc", pc0, 32'h40);
        check("ds0_r2_ir", ir0, 32'h10);
        repeat (3) step;
        check("ds1_len", 32'(q1.size()), 32'd5);
        check("ds1_q0", qat(q1, 0), 32'h10);
        check("ds1_q1", qat(q1, 1), 32'h14);
        check("ds1_q2", qat(q1, 2), 32'h40);
        check("ds1_q3", qat(q1, 3), 32'h44);
        check("ds1_q4", qat(q1, 4), 32'h48);
        check("ds0_len", 32'(q0.size()), 32'd4);
        check("ds0_q0", qat(q0, 0), 32'h10);
        check("ds0_q1", qat(q0, 1), 32'h40);
        check("ds0_q2", qat(q0, 2), 32'h44);
        check("ds0_q3", qat(q0, 3), 32'h48);

        // Halt drains FIFO plus in-flight word
        do_reset;
        stall = 1'b1;
        repeat (4) step;
        check("halt_pre_count", 32'(cnt1), 32'd3);
        halt = 1'b1;
        stall = 1'b0;
        #1;
        check("halt_en", 32'(en1), 32'd0);
        q1.delete();
        repeat (6) step;
        check("halt_len", 32'(q1.size()), 32'd4);
        check("halt_q0", qat(q1, 0), 32'h0);
        check("halt_q1", qat(q1, 1), 32'h4);
        check("halt_q2", qat(q1, 2), 32'h8);
        check("halt_q3", qat(q1, 3), 32'hc);
        check("halt_valid", 32'(v1), 32'd0);
        check("halt_ir", ir1, 32'h20);
        check("halt_count", 32'(cnt1), 32'd0);
        halt = 1'b0;
        step;
        step;
        check("resume_valid", 32'(v1), 32'd1);
        check("resume_pc", pc1, 32'h10);
        check("resume_ir", ir1, 32'h4);

        // Reset mid-operation discards in-flight data
        do_reset;
        stall = 1'b1;
        repeat (4) step;
        check("mrst_pre_count", 32'(cnt1), 32'd3);
        rst = 1'b1;
        stall = 1'b0;
        step;
        check("mrst_count", 32'(cnt1), 32'd0);
        check("mrst_valid", 32'(v1), 32'd0);
        rst = 1'b0;
        step;
        check("mrst_e1_valid", 32'(v1), 32'd0);
        step;
        check("mrst_e2_valid", 32'(v1), 32'd1);
        check("mrst_e2_pc", pc1, 32'h0);
        check("mrst_e2_ir", ir1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
